// File: rtl/if_fetch_queue.sv
// Purpose: instruction fetch unit; issues single-beat AXI reads and unpacks each beat into a DEPTH-entry {pc, inst, fault} queue for ID.
// Latency: from an idle FSM, ARVALID the next cycle, then the head entry is valid one cycle after the RVALID handshake (min 3 cycles).
// Backpressure: out_ready low stalls the queue; a new read is issued only when the queue has room for the whole unpacked beat.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   redirect_valid/_pc       flush the queue and restart fetch at redirect_pc (bits [1:0] dropped)
//   out_valid/out_ready      head-of-queue handshake towards ID
//   out_pc/out_inst/out_fault head entry contents (meaningful only while out_valid=1)
//   fetch_idle               FSM idle, no AXI read transaction open
//   IFU_AXI_AR*              read address channel (single beat, INCR, constant ID)
//   IFU_AXI_R*               read data channel (RID and RLAST are not used)
module if_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 64,
  parameter int                DEPTH    = 4,
  parameter int                AXI_ID   = 0,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_inst,
  output logic              out_fault,
  output logic              fetch_idle,

  output logic [3:0]        IFU_AXI_ARID,
  output logic [ADDR_W-1:0] IFU_AXI_ARADDR,
  output logic [7:0]        IFU_AXI_ARLEN,
  output logic [2:0]        IFU_AXI_ARSIZE,
  output logic [1:0]        IFU_AXI_ARBURST,
  output logic              IFU_AXI_ARVALID,
  input  logic              IFU_AXI_ARREADY,
  input  logic [3:0]        IFU_AXI_RID,
  input  logic [DATA_W-1:0] IFU_AXI_RDATA,
  input  logic [1:0]        IFU_AXI_RRESP,
  input  logic              IFU_AXI_RLAST,
  input  logic              IFU_AXI_RVALID,
  output logic              IFU_AXI_RREADY
);

  // Words per beat, bytes per beat and the byte-offset width inside a beat.
  localparam int W     = DATA_W / 32;
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       inst;
    logic              fault;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_DROP
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] ar_addr;     // beat-aligned address of the open read
  logic              drop_pend;   // redirect seen while the AR was still pending
  logic              arvalid_q;
  logic              rready_q;
  logic              idle_q;

  entry_t            mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;

  // ---------------------------------------------------------------------------
  // Fetch geometry: k is the first useful word of the beat, need is how many
  // entries the beat will produce, free is the space currently in the queue.
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] pc_aligned;
  logic [ADDR_W-1:0] pc_offset;
  logic [CW-1:0]     k;
  logic [CW-1:0]     need;
  logic [CW-1:0]     free;

  assign pc_aligned = fetch_pc & ~ADDR_W'(BYTES - 1);
  assign pc_offset  = fetch_pc &  ADDR_W'(BYTES - 1);
  assign k          = CW'(pc_offset >> 2);
  assign need       = CW'(W) - k;
  assign free       = CW'(DEPTH) - count;

  logic push;
  logic pop;

  // A redirect in the same cycle as the beat wins: the beat belongs to the
  // abandoned path and nothing from it may enter the queue.
  assign push = (state == S_R) && IFU_AXI_RVALID && !redirect_valid;
  assign pop  = (count != '0) && out_ready;

  // ---------------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      ar_addr   <= '0;
      drop_pend <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      end

      case (state)
        S_IDLE: begin
          if (!redirect_valid && (free >= need)) begin
            state     <= S_AR;
            ar_addr   <= pc_aligned;
            arvalid_q <= 1'b1;
            idle_q    <= 1'b0;
            drop_pend <= 1'b0;
          end
        end

        // ARVALID and ARADDR stay put until the slave takes them, even when a
        // redirect arrives; the response is then swallowed in S_DROP.
        S_AR: begin
          if (IFU_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            drop_pend <= 1'b0;
            state     <= (drop_pend || redirect_valid) ? S_DROP : S_R;
          end else if (redirect_valid) begin
            drop_pend <= 1'b1;
          end
        end

        S_R: begin
          if (IFU_AXI_RVALID) begin
            state    <= S_IDLE;
            rready_q <= 1'b0;
            idle_q   <= 1'b1;
            if (!redirect_valid) begin
              fetch_pc <= ar_addr + ADDR_W'(BYTES);
            end
          end else if (redirect_valid) begin
            state <= S_DROP;
          end
        end

        S_DROP: begin
          if (IFU_AXI_RVALID) begin
            state    <= S_IDLE;
            rready_q <= 1'b0;
            idle_q   <= 1'b1;
          end
        end

        default: begin
          state     <= S_IDLE;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          idle_q    <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Queue pointers and occupancy. A push adds `need` entries at once.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= PW'((int'(rd_ptr) + 1) % DEPTH);
      end
      if (push) begin
        wr_ptr <= PW'((int'(wr_ptr) + int'(need)) % DEPTH);
      end
      count <= count + (push ? need : CW'(0)) - (pop ? CW'(1) : CW'(0));
    end
  end

  // ---------------------------------------------------------------------------
  // Queue storage: word i of the beat (i >= k) lands i-k slots past wr_ptr.
  // Data is not reset; out_valid qualifies it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < W; i++) begin
        if (i >= int'(k)) begin
          mem[PW'((int'(wr_ptr) + i - int'(k)) % DEPTH)] <= '{
            pc:    ar_addr + ADDR_W'(4 * i),
            inst:  IFU_AXI_RDATA[32*i +: 32],
            fault: (IFU_AXI_RRESP != 2'b00)
          };
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  entry_t head;
  assign head      = mem[rd_ptr];

  assign out_valid = (count != '0);
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;
  assign out_fault = head.fault;
  assign fetch_idle = idle_q;

  assign IFU_AXI_ARID    = 4'(AXI_ID);
  assign IFU_AXI_ARADDR  = ar_addr;
  assign IFU_AXI_ARLEN   = 8'd0;
  assign IFU_AXI_ARSIZE  = 3'(OFF_W);
  assign IFU_AXI_ARBURST = 2'b01;
  assign IFU_AXI_ARVALID = arvalid_q;
  assign IFU_AXI_RREADY  = rready_q;

  // Single-beat reads with one outstanding transaction make RID and RLAST
  // redundant; redirect_pc[1:0] is dropped because instructions are word aligned.
  logic unused_ok;
  assign unused_ok = ^{IFU_AXI_RID, IFU_AXI_RLAST, redirect_pc[1:0]};

endmodule
